// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: round-robin, whole-packet arbiter muxing the ICMP and UDP tx byte streams onto IP tx.
// Define ARB_TIMEOUT_EN to add a watchdog that revokes a grant whose owner never sends a first byte.
module ip_tx_arbiter #(
  parameter logic [7:0]  P_ICMP_TYPE = 8'd1,
  parameter logic [7:0]  P_UDP_TYPE  = 8'd17,
  parameter int unsigned P_GAP       = 2,
  parameter int unsigned P_TIMEOUT   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_icmp_req,
  output logic        o_icmp_grant,
  input  logic [7:0]  i_icmp_data,
  input  logic [15:0] i_icmp_len,
  input  logic        i_icmp_last,
  input  logic        i_icmp_valid,
  input  logic        i_udp_req,
  output logic        o_udp_grant,
  input  logic [7:0]  i_udp_data,
  input  logic [15:0] i_udp_len,
  input  logic        i_udp_last,
  input  logic        i_udp_valid,
  input  logic        i_ip_ready,
  output logic [7:0]  o_ip_data,
  output logic [15:0] o_ip_len,
  output logic [7:0]  o_ip_type,
  output logic        o_ip_last,
  output logic        o_ip_valid,
  output logic        o_drop,
  output logic        o_timeout,
  output logic        o_busy
);

  if (P_GAP == 0 || P_GAP > 255 || P_TIMEOUT == 0 || P_TIMEOUT > 65535) begin : g_param_check
    $error("ip_tx_arbiter: P_GAP or P_TIMEOUT out of range");
  end

  localparam logic [7:0] GAP_LAST = 8'(P_GAP - 1);

  typedef enum logic [1:0] {IDLE, GNT_ICMP, GNT_UDP, GAP} state_t;

  state_t      state, state_nxt;
  logic        last_udp, last_udp_nxt;
  logic        cur_udp, cur_udp_nxt;
  logic        got_first, got_first_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic [7:0]  type_nxt;
  logic        sel_req, sel_valid, sel_last;
  logic [7:0]  sel_data;
  logic [15:0] sel_len;
  logic        fwd_vld, drop_nxt;

  logic [7:0]  data_p1, type_p1;
  logic [15:0] len_p1;
  logic        vld_p1, last_p1, drop_p1;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(P_TIMEOUT);

  logic [15:0] tmo_cnt, tmo_cnt_nxt, tmo_inc;
  logic        tmo_fire, tmo_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  always_comb begin
    sel_req       = (state == GNT_UDP) ? i_udp_req   : i_icmp_req;
    sel_valid     = (state == GNT_UDP) ? i_udp_valid : i_icmp_valid;
    sel_last      = (state == GNT_UDP) ? i_udp_last  : i_icmp_last;
    sel_data      = (state == GNT_UDP) ? i_udp_data  : i_icmp_data;
    sel_len       = (state == GNT_UDP) ? i_udp_len   : i_icmp_len;
    drop_nxt      = (i_icmp_valid && state != GNT_ICMP) || (i_udp_valid && state != GNT_UDP);
    fwd_vld       = 1'b0;
    state_nxt     = state;
    last_udp_nxt  = last_udp;
    cur_udp_nxt   = cur_udp;
    got_first_nxt = got_first;
    gap_cnt_nxt   = '0;
    type_nxt      = type_p1;
`ifdef ARB_TIMEOUT_EN
    tmo_inc       = sat_inc16(tmo_cnt);
    tmo_cnt_nxt   = tmo_cnt;
    tmo_fire      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (i_ip_ready && (i_icmp_req || i_udp_req)) begin
          got_first_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_nxt   = '0;
`endif
          // On a tie the source not served last wins.
          if (i_icmp_req && (!i_udp_req || last_udp)) begin
            state_nxt   = GNT_ICMP;
            cur_udp_nxt = 1'b0;
            type_nxt    = P_ICMP_TYPE;
          end else begin
            state_nxt   = GNT_UDP;
            cur_udp_nxt = 1'b1;
            type_nxt    = P_UDP_TYPE;
          end
        end
      end
      GNT_ICMP, GNT_UDP: begin
        if (sel_valid) begin
          fwd_vld       = 1'b1;
          got_first_nxt = 1'b1;
          if (sel_last) state_nxt = GAP;
        end else if (!got_first) begin
          if (!sel_req) begin
            state_nxt = GAP;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            tmo_cnt_nxt = tmo_inc;
            if (tmo_inc >= TMO_LIM) begin
              state_nxt = GAP;
              tmo_fire  = 1'b1;
            end
          end
`endif
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt    = IDLE;
          last_udp_nxt = cur_udp;
        end else begin
          gap_cnt_nxt  = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      last_udp  <= 1'b1;
      cur_udp   <= 1'b1;
      got_first <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      last_udp  <= last_udp_nxt;
      cur_udp   <= cur_udp_nxt;
      got_first <= got_first_nxt;
      gap_cnt   <= gap_cnt_nxt;
    end
  end

  // Stage p1: registered output stream; reset truncates any packet in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_p1 <= '0;
      len_p1  <= '0;
      type_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      drop_p1 <= 1'b0;
    end else begin
      if (fwd_vld) data_p1 <= sel_data;
      if (fwd_vld && !got_first) len_p1 <= sel_len;
      type_p1 <= type_nxt;
      vld_p1  <= fwd_vld;
      last_p1 <= fwd_vld && sel_last;
      drop_p1 <= drop_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt <= '0;
      tmo_p1  <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
      tmo_p1  <= tmo_fire;
    end
  end

  assign o_timeout = tmo_p1;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_icmp_grant = (state == GNT_ICMP);
  assign o_udp_grant  = (state == GNT_UDP);
  assign o_busy       = (state != IDLE);
  assign o_ip_data    = data_p1;
  assign o_ip_len     = len_p1;
  assign o_ip_type    = type_p1;
  assign o_ip_last    = last_p1;
  assign o_ip_valid   = vld_p1;
  assign o_drop       = drop_p1;

endmodule
